// File: rtl/iseq_loader.sv
// Instruction-sequence loader: alternates host words across two lane FIFOs,
// pads odd-length sequences with a NOP, then launches the dispatcher.
module iseq_loader #(
  parameter logic [3:0]  END_OPCODE = 4'hF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int          MAX_LEN    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        instr0_fifo_wr,
  output logic [31:0] instr0_fifo_din,
  input  logic        instr0_fifo_full,
  output logic        instr1_fifo_wr,
  output logic [31:0] instr1_fifo_din,
  input  logic        instr1_fifo_full,
  output logic        process_iseq,
  input  logic        dispatcher_busy,
  output logic        loader_busy,
  output logic [15:0] iseq_len,
  output logic        overflow
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, PAD, START, WAIT_HI, WAIT_LO} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            lane_q, lane_d;
  logic [15:0]     len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      full, wr;
  logic [1:0][31:0] din;
  logic            is_end;

  assign full   = {instr1_fifo_full, instr0_fifo_full};
  assign is_end = (in_data[31:28] == END_OPCODE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lane_d       = lane_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    wr           = '0;
    din          = '0;
    in_ready     = 1'b0;
    process_iseq = 1'b0;
    cnt_inc      = cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        // rst gates the handshake so nothing is written while held in reset
        in_ready = ~dispatcher_busy & ~full[lane_q] & ~rst;
        if (in_valid && in_ready) begin
          if (cnt_q == '0) ovf_d = 1'b0;
          if (!is_end) begin
            wr[lane_q]  = 1'b1;
            din[lane_q] = in_data;
            cnt_d       = cnt_inc;
            lane_d      = ~lane_q;
            // lane_q==0 before this write means the new count is odd
            if (cnt_inc == CW'(MAX_LEN)) begin
              ovf_d   = 1'b1;
              state_d = lane_q ? START : PAD;
            end
          end else if (cnt_q != '0) begin
            state_d = lane_q ? PAD : START;
          end
        end
      end
      PAD: begin
        if (!instr1_fifo_full && !rst) begin
          wr[1]   = 1'b1;
          din[1]  = NOP_INSTR;
          state_d = START;
        end
      end
      START: begin
        process_iseq = 1'b1;
        len_d        = 16'(cnt_q);
        cnt_d        = '0;
        lane_d       = 1'b0;
        state_d      = WAIT_HI;
      end
      WAIT_HI: if (dispatcher_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!dispatcher_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign instr0_fifo_wr  = wr[0];
  assign instr0_fifo_din = din[0];
  assign instr1_fifo_wr  = wr[1];
  assign instr1_fifo_din = din[1];
  assign loader_busy     = (state_q != IDLE);
  assign iseq_len        = len_q;
  assign overflow        = ovf_q;
endmodule

// File: doc/iseq_loader.md
ISEQ_LOADER -- requirements
Module: iseq_loader

Interface
REQ-001 SHALL have parameter END_OPCODE, default 4'hF, the value of instruction bits [31:28] that marks end-of-sequence.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, the pad word written to instr1 when a sequence holds an odd number of instructions.
REQ-003 SHALL have parameter MAX_LEN, default 1024, the maximum number of instructions per sequence, excluding END and pad.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: a host instruction word is present.
REQ-007 Port in_data, input, 32: the host instruction word.
REQ-008 Port in_ready, output, 1: the word is accepted in any cycle where in_valid and in_ready are both high.
REQ-009 Port instr0_fifo_wr, output, 1: write strobe for the lane-0 FIFO.
REQ-010 Port instr0_fifo_din, output, 32: write data for the lane-0 FIFO.
REQ-011 Port instr0_fifo_full, input, 1: the lane-0 FIFO is full.
REQ-012 Ports instr1_fifo_wr, instr1_fifo_din and instr1_fifo_full SHALL mirror REQ-009 to REQ-011 for lane 1.
REQ-013 Port process_iseq, output, 1: one-cycle start pulse to the dispatcher.
REQ-014 Port dispatcher_busy, input, 1: the dispatcher is executing a sequence.
REQ-015 Port loader_busy, output, 1: high whenever the state is not IDLE.
REQ-016 Port iseq_len, output, 16: instruction count of the last launched sequence.
REQ-017 Port overflow, output, 1: sticky flag, set when the last sequence reached MAX_LEN.

Function
REQ-018 SHALL implement the states IDLE, PAD, START, WAIT_HI and WAIT_LO.
REQ-019 Lane pointer: starts at 0 and toggles after every instruction written, so instructions 0,2,4,… go to lane 0 and 1,3,5,… go to lane 1.
REQ-020 IDLE: in_ready = ~dispatcher_busy & ~full[lane]; each handshake is one of two cases.
  - Non-END word: written to the FIFO at the lane pointer in the same cycle (combinational wr/din); counter increments.
  - END word: not written.
REQ-021 END accepted with count 0: stay in IDLE, no pulse, no writes, iseq_len unchanged.
REQ-022 END accepted with count odd (lane pointer = 1): go to PAD.
REQ-023 END accepted with count even and nonzero: go to START.
REQ-024 Count reaches MAX_LEN on a non-END write: implicit END.
  - Set overflow.
  - Take the odd/even transition of REQ-022/REQ-023.
  - A subsequent host END word is treated as a new empty sequence (REQ-021).
REQ-025 PAD: assert instr1_fifo_wr with NOP_INSTR while instr1_fifo_full is low, then go to START; in_ready = 0.
REQ-026 START: process_iseq = 1 for exactly one cycle.
  - iseq_len latches the count.
  - Counter and lane pointer clear.
  - Go to WAIT_HI.
REQ-027 WAIT_HI: leave for WAIT_LO when dispatcher_busy = 1.
REQ-028 WAIT_LO: leave for IDLE when dispatcher_busy = 0.
REQ-029 in_ready SHALL be 0 in every state other than IDLE.
REQ-030 overflow clears at the first accepted word of the next sequence.
REQ-031 Never write both FIFOs in the same cycle; never assert a write strobe while that lane's full is high.
REQ-032 The counter width SHALL be clog2(MAX_LEN+1); iseq_len is zero-extended to 16 bits.

Reset
REQ-033 On rst, outputs and state SHALL take these values:
  - State = IDLE.
  - Counter and lane pointer = 0.
  - iseq_len = 0, overflow = 0, process_iseq = 0, loader_busy = 0.
  - Both write strobes = 0.
  - Data outputs = 0 when not writing.
REQ-034 rst asserted mid-sequence SHALL abandon the sequence with no pad and no pulse; flushing the FIFOs is external.

Verification
REQ-035 Sequence A,B,C,END with FIFOs not full -> lane0 gets A,C; lane1 gets B,32'h0; one process_iseq pulse; iseq_len = 3.
REQ-036 Sequence A,B,END -> no pad write; process_iseq pulses the cycle after the END state transition; iseq_len = 2.
REQ-037 Lone END -> no writes, no pulse, state stays IDLE.
REQ-038 instr1_fifo_full held high for 5 cycles during word B -> in_ready = 0 for those 5 cycles; B is written on the first cycle full drops; no word lost or duplicated.
REQ-039 MAX_LEN = 4, five non-END words sent -> four written, overflow = 1, pulse issued, fifth word stalls until the WAIT_LO to IDLE transition.
REQ-040 Drive dispatcher_busy 1 for 10 cycles after the pulse, then rst during a new load -> in_ready stays 0 until busy falls; after rst all outputs are 0 and state is IDLE.
